// File: rtl/ascii_to_b7_if.sv
`default_nettype none
// ascii_to_b7_if: valid/ready character handshake into the serial transmitter.
// Rev 1.0
interface ascii_to_b7_if;
  logic [6:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/ascii_to_b7.sv
`default_nettype none
// ascii_to_b7: FIFO-buffered 7-bit MSB-first serializer with idle-character fill.
// Rev 1.0
module ascii_to_b7 #(
  parameter int         DEPTH     = 4,
  parameter logic [6:0] IDLE_CHAR = 7'h16,
  localparam int        LW        = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ascii_to_b7_if.slave       in_if,
  output logic               out,
  output logic               frame_start,
  output logic               sending_idle,
  output logic [LW-1:0]      fifo_level
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);

  logic [6:0]    shreg;
  logic [2:0]    bit_idx;
  logic          idle_flag;
  logic [6:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic          empty;
  logic          push;
  logic          load;
  logic          pop;

  assign empty          = (count == '0);
  assign in_if.in_ready = (count != FULL_COUNT);
  assign push           = in_if.in_valid && in_if.in_ready;
  assign load           = (bit_idx == 3'd6);
  // The load edge sees the pre-edge FIFO state: no bypass of a same-cycle write.
  assign pop            = load && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= IDLE_CHAR;
      bit_idx   <= 3'd0;
      idle_flag <= 1'b1;
    end else if (load) begin
      bit_idx <= 3'd0;
      if (!empty) begin
        shreg     <= mem[rd_ptr];
        idle_flag <= 1'b0;
      end else begin
        shreg     <= IDLE_CHAR;
        idle_flag <= 1'b1;
      end
    end else begin
      shreg   <= {shreg[5:0], 1'b0};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_if.in_data;
  end

  assign out          = shreg[6];
  assign frame_start  = (bit_idx == 3'd0);
  assign sending_idle = idle_flag;
  assign fifo_level   = count;

endmodule
`default_nettype wire

// File: tb/tb_ascii_to_b7.sv
`default_nettype none
// tb_ascii_to_b7: randomized and directed checks against a frame/queue reference model.
// Rev 1.0
module tb_ascii_to_b7;

  localparam int         DEPTH     = 4;
  localparam logic [6:0] IDLE_CHAR = 7'h16;
  localparam int         LW        = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          out;
  logic          frame_start;
  logic          sending_idle;
  logic [LW-1:0] fifo_level;

  ascii_to_b7_if bus ();

  ascii_to_b7 #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE_CHAR)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .out          (out),
    .frame_start  (frame_start),
    .sending_idle (sending_idle),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] q[$];
  logic [6:0] acc[$];
  logic [6:0] rx[$];
  logic [6:0] cur;
  logic       cur_idle;
  logic [6:0] word;
  int         cyc;
  bit         accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    acc.delete();
    rx.delete();
    cur      = IDLE_CHAR;
    cur_idle = 1'b1;
    cyc      = 0;
    word     = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out"},   32'(out),            32'(IDLE_CHAR[6]));
    chk({tag, "_fs"},    32'(frame_start),    32'd1);
    chk({tag, "_idle"},  32'(sending_idle),   32'd1);
    chk({tag, "_level"}, 32'(fifo_level),     32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready),   32'd1);
  endtask

  // Called at a negedge: compare, present inputs, advance model across one posedge.
  task automatic cycle(input logic v, input logic [6:0] d);
    int pos;
    pos = cyc % 7;
    chk("out",          32'(out),          32'(cur[6-pos]));
    chk("frame_start",  32'(frame_start),  32'(pos == 0));
    chk("sending_idle", 32'(sending_idle), 32'(cur_idle));
    chk("fifo_level",   32'(fifo_level),   32'(q.size()));
    chk("in_ready",     32'(bus.in_ready), 32'(q.size() < DEPTH));
    word = {word[5:0], out};
    if (pos == 6 && !cur_idle) rx.push_back(word);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    begin
      bit rdy;
      rdy = (q.size() < DEPTH);
      if (pos == 6) begin
        if (q.size() != 0) begin
          cur      = q.pop_front();
          cur_idle = 1'b0;
        end else begin
          cur      = IDLE_CHAR;
          cur_idle = 1'b1;
        end
      end
      accepted = v && rdy;
      if (accepted) begin
        q.push_back(d);
        acc.push_back(d);
      end
    end
    cyc++;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] d, input string tag);
    int n;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 100) begin
      cycle(1'b1, d);
      n++;
    end
    chk({tag, "_accept"}, 32'(accepted), 32'd1);
  endtask

  initial begin
    logic [6:0] hello [5];
    int n;
    hello[0] = 7'h48; hello[1] = 7'h45; hello[2] = 7'h4C; hello[3] = 7'h4C; hello[4] = 7'h4F;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;

    // Idle stream for three frames
    repeat (21) cycle(1'b0, 7'h00);

    // Single character written two cycles into a frame
    repeat (2) cycle(1'b0, 7'h00);
    cycle(1'b1, 7'h41);
    repeat (18) cycle(1'b0, 7'h00);

    // Back-to-back HELLO holding in_valid
    for (int i = 0; i < 5; i++) send(hello[i], "hello");
    repeat (42) cycle(1'b0, 7'h00);

    // Write exactly on the load edge with the FIFO empty
    n = 0;
    while ((q.size() != 0 || cyc % 7 != 6) && n < 100) begin
      cycle(1'b0, 7'h00);
      n++;
    end
    cycle(1'b1, 7'h5A);
    repeat (21) cycle(1'b0, 7'h00);

    // Mid-frame reset with characters queued
    for (int i = 0; i < 3; i++) send(7'(8'h61 + i), "preq");
    while (cyc % 7 != 3) cycle(1'b0, 7'h00);
    chk("preq_level", 32'(fifo_level), 32'(q.size()));
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    repeat (14) cycle(1'b0, 7'h00);

    // Random characters with random valid gaps
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 7'($urandom_range(0, 127)));
      send(7'($urandom_range(0, 127)), "rand");
    end
    repeat (7 * (DEPTH + 2)) cycle(1'b0, 7'h00);

    chk("rx_count", 32'(rx.size()), 32'(acc.size()));
    for (int i = 0; i < acc.size() && i < rx.size(); i++) chk("rx_word", 32'(rx[i]), 32'(acc[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
